vga_timing_ctrl: RTL
====================

VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

Interface
REQ-001 Parameter: H_SYNC, default 96, hsync pulse width in vga_clk cycles.
REQ-002 Parameter: H_BACK, default 48, horizontal back porch in cycles.
REQ-003 Parameter: H_VALID, default 640, visible pixels per line.
REQ-004 Parameter: H_FRONT, default 16, horizontal front porch in cycles.
REQ-005 Parameter: V_SYNC, default 2, vsync pulse width in lines.
REQ-006 Parameter: V_BACK, default 33, vertical back porch in lines.
REQ-007 Parameter: V_VALID, default 480, visible lines per frame.
REQ-008 Parameter: V_FRONT, default 10, vertical front porch in lines.
REQ-009 Port: vga_clk, input, 1 bit, pixel clock, 25 MHz, all state on rising edge.
REQ-010 Port: sys_rst_n, input, 1 bit, reset, asynchronous, active-low.
REQ-011 Port: pix_data, input, 16 bits, RGB565 colour returned by the pixel generator for the current pix_x/pix_y.
REQ-012 Port: pix_x, output, 10 bits, X coordinate of the current visible pixel, 10'h3FF outside the visible area.
REQ-013 Port: pix_y, output, 10 bits, Y coordinate of the current visible pixel, 10'h3FF outside the visible area.
REQ-014 Port: hsync, output, 1 bit, horizontal sync, active-low.
REQ-015 Port: vsync, output, 1 bit, vertical sync, active-low.
REQ-016 Port: de, output, 1 bit, data enable, high during visible pixels.
REQ-017 Port: rgb, output, 16 bits, RGB565 colour to the DAC.
REQ-018 Port: frame_start, output, 1 bit, one-cycle pulse at the first cycle of each frame.

Function
REQ-019 H_TOTAL SHALL equal H_SYNC+H_BACK+H_VALID+H_FRONT (800 by default), and V_TOTAL SHALL equal V_SYNC+V_BACK+V_VALID+V_FRONT (525 by default).
REQ-020 A 10-bit register cnt_h SHALL increment every cycle and wrap from H_TOTAL-1 to 0.
REQ-021 A 10-bit register cnt_v SHALL increment only in cycles where cnt_h==H_TOTAL-1, and SHALL wrap from V_TOTAL-1 to 0 in that same cycle.
REQ-022 hsync SHALL be 0 when cnt_h<H_SYNC and 1 otherwise; vsync SHALL be 0 when cnt_v<V_SYNC and 1 otherwise.
REQ-023 The visible area SHALL be cnt_h in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_VALID-1] (144..783) and cnt_v in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_VALID-1] (35..514).
REQ-024 Inside the visible area, pix_x SHALL equal cnt_h-(H_SYNC+H_BACK) and pix_y SHALL equal cnt_v-(V_SYNC+V_BACK); both are combinational from the counters, 0-cycle latency.
REQ-025 Outside the visible area, pix_x and pix_y SHALL both be 10'h3FF.
REQ-026 de SHALL be high exactly in the visible area; rgb SHALL equal pix_data when de=1 and 16'h0000 otherwise.
REQ-027 frame_start SHALL be high exactly when cnt_h==0 and cnt_v==0.
REQ-028 pix_data SHALL be treated as a combinational function of pix_x/pix_y in the same cycle; the block adds no handshake.

Reset
REQ-029 While sys_rst_n=0, cnt_h and cnt_v SHALL be 0, which gives hsync=0, vsync=0, de=0, rgb=0, pix_x=pix_y=10'h3FF and frame_start=1 in unregistered mode.
REQ-030 Reset asserted mid-frame SHALL force the counters to 0 immediately, asynchronously.
REQ-031 After sys_rst_n deasserts, the first rising edge SHALL take cnt_h to 1, and frame timing restarts from frame position 0.

Configuration
REQ-032 Macro VGA_OUT_REG_EN: when defined, hsync, vsync, de, rgb and frame_start SHALL be registered on vga_clk.
REQ-033 With VGA_OUT_REG_EN defined, these registered outputs SHALL have 1 cycle of latency relative to the counter-derived values, while pix_x/pix_y keep 0 latency.
REQ-034 With VGA_OUT_REG_EN defined, the registered outputs SHALL reset to hsync=1, vsync=1, de=0, rgb=0, frame_start=0.
REQ-035 Without VGA_OUT_REG_EN, the outputs SHALL be combinational as in REQ-022..027.

Verification
REQ-036 Release reset, then count cycles -> hsync low for 96 cycles per 800-cycle period, vsync low for 1600 cycles per 420000-cycle frame.
REQ-037 Tie pix_data=16'hF81F -> de high for 640 consecutive cycles per line on 480 lines per frame, with rgb=16'hF81F only when de=1 and 0 otherwise.
REQ-038 Check the area edges -> at cnt_h=144, cnt_v=35: pix_x=0, pix_y=0; at cnt_h=783, cnt_v=514: pix_x=639, pix_y=479; at cnt_h=784: pix_x=10'h3FF.
REQ-039 Check the wrap -> cnt_h=799, cnt_v=524 is followed by cnt_h=0, cnt_v=0, and frame_start pulses exactly once per 420000 cycles.
REQ-040 Assert reset at cnt_v=200 -> counters go to 0 without waiting for a clock edge, and after release the first frame_start occurs 420000 cycles after the previous frame start post-reset.
REQ-041 Build with VGA_OUT_REG_EN -> hsync/de/rgb edges are delayed by exactly 1 cycle versus the unregistered build, and pix_x is unchanged.

Source files
------------

// File: rtl/vga_timing_ctrl_if.sv
// Pixel/sync bundle between the VGA timing controller (master) and the
// pixel generator / DAC side (slave).
interface vga_timing_ctrl_if;
    logic [15:0] pix_data;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [15:0] rgb;
    logic        frame_start;

    modport master (
        input  pix_data,
        output pix_x, pix_y, hsync, vsync, de, rgb, frame_start
    );

    modport slave (
        output pix_data,
        input  pix_x, pix_y, hsync, vsync, de, rgb, frame_start
    );
endinterface

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing: free-running h/v counters, active-low syncs, data enable.
// Define VGA_OUT_REG_EN to register hsync/vsync/de/rgb/frame_start (1-cycle delay).
module vga_timing_ctrl #(
    parameter int H_SYNC  = 96,
    parameter int H_BACK  = 48,
    parameter int H_VALID = 640,
    parameter int H_FRONT = 16,
    parameter int V_SYNC  = 2,
    parameter int V_BACK  = 33,
    parameter int V_VALID = 480,
    parameter int V_FRONT = 10
) (
    input  logic               vga_clk,
    input  logic               sys_rst_n,
    vga_timing_ctrl_if.master  vga
);
    localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;

    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SW    = 10'(H_SYNC);
    localparam logic [9:0] V_SW    = 10'(V_SYNC);
    localparam logic [9:0] H_ACT_S = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] H_ACT_E = 10'(H_SYNC + H_BACK + H_VALID);
    localparam logic [9:0] V_ACT_S = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] V_ACT_E = 10'(V_SYNC + V_BACK + V_VALID);

    logic [9:0] cnt_h_q, cnt_h_d;
    logic [9:0] cnt_v_q, cnt_v_d;

    always_comb begin
        cnt_h_d = (cnt_h_q == H_LAST) ? 10'd0 : cnt_h_q + 10'd1;
        cnt_v_d = cnt_v_q;
        if (cnt_h_q == H_LAST)
            cnt_v_d = (cnt_v_q == V_LAST) ? 10'd0 : cnt_v_q + 10'd1;
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_h_q <= '0;
            cnt_v_q <= '0;
        end else begin
            cnt_h_q <= cnt_h_d;
            cnt_v_q <= cnt_v_d;
        end
    end

    // Counter-derived (unregistered) output values
    logic        hsync_d, vsync_d, de_d, frame_start_d;
    logic [15:0] rgb_d;

    always_comb begin
        hsync_d       = (cnt_h_q >= H_SW);
        vsync_d       = (cnt_v_q >= V_SW);
        de_d          = (cnt_h_q >= H_ACT_S) && (cnt_h_q < H_ACT_E) &&
                        (cnt_v_q >= V_ACT_S) && (cnt_v_q < V_ACT_E);
        rgb_d         = de_d ? vga.pix_data : 16'h0000;
        frame_start_d = (cnt_h_q == 10'd0) && (cnt_v_q == 10'd0);
    end

    // Coordinates stay combinational in both builds so the pixel generator
    // sees them in the same cycle it must answer.
    assign vga.pix_x = de_d ? (cnt_h_q - H_ACT_S) : 10'h3FF;
    assign vga.pix_y = de_d ? (cnt_v_q - V_ACT_S) : 10'h3FF;

`ifdef VGA_OUT_REG_EN
    logic        hsync_q, vsync_q, de_q, frame_start_q;
    logic [15:0] rgb_q;

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            de_q          <= 1'b0;
            rgb_q         <= 16'h0000;
            frame_start_q <= 1'b0;
        end else begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            rgb_q         <= rgb_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.de          = de_q;
    assign vga.rgb         = rgb_q;
    assign vga.frame_start = frame_start_q;
`else
    assign vga.hsync       = hsync_d;
    assign vga.vsync       = vsync_d;
    assign vga.de          = de_d;
    assign vga.rgb         = rgb_d;
    assign vga.frame_start = frame_start_d;
`endif
endmodule
